mips_mem_arbiter: RTL and testbench
===================================

// Module: mips_mem_arbiter
// PURPOSE
//  Shares one unified, Avalon-style memory port between the CPU instruction-fetch port and data port.
//  Sits between mips_cpu_harvard-style fetch/data masters and a single RAM/ROM slave.
//  Arbitration is round-robin on ties. The granted request is latched, so the slave sees stable signals.
//  Each requester gets a waitrequest-style completion handshake.
// PARAMETERS
//  ADDR_W  32  address width, all ports
//  DATA_W  32  data width, all ports; byteenable width is DATA_W/8
// PORTS
//  clk            in   1       single clock, all state on posedge
//  reset          in   1       asynchronous, active-high
//  i_read         in   1       instruction fetch request
//  i_address      in   ADDR_W  fetch byte address
//  i_readdata     out  DATA_W  fetch data, valid when i_read && !i_waitrequest
//  i_waitrequest  out  1       0 = fetch completes this cycle
//  d_read         in   1       data read request
//  d_write        in   1       data write request
//  d_address      in   ADDR_W  data byte address
//  d_writedata    in   DATA_W  store data
//  d_byteenable   in   DATA_W/8  store/load lane enables
//  d_readdata     out  DATA_W  load data, valid when d_read && !d_waitrequest
//  d_waitrequest  out  1       0 = data access completes this cycle
//  m_read         out  1       slave read strobe
//  m_write        out  1       slave write strobe
//  m_address      out  ADDR_W  latched address
//  m_writedata    out  DATA_W  latched store data
//  m_byteenable   out  DATA_W/8  latched lanes; all-ones for fetch
//  m_readdata     in   DATA_W  slave read data
//  m_waitrequest  in   1       slave stall
// BEHAVIOUR
//  Reset values: state=IDLE, last_grant=DATA, m_read=m_write=0, m_* regs=0.
//   Also i/d_waitrequest=1 and i/d_readdata=0.
//  FSM states are IDLE, BUSY_I and BUSY_D.
//  IDLE, no request: stay IDLE.
//  IDLE, only fetch requests: capture {i_address, be=all-ones, read} into regs -> BUSY_I.
//  IDLE, only data requests: capture {d_address, d_writedata, d_byteenable, kind} -> BUSY_D.
//  IDLE, both request: grant the side opposite last_grant, then update last_grant.
//  BUSY_x: drive m_* from regs. Stay while m_waitrequest=1.
//  BUSY_x, m_waitrequest=0: pull the owner's waitrequest low in the same cycle (combinational).
//   For reads, forward m_readdata to the owner's readdata. Next state is IDLE.
//  Minimum latency is 2 cycles (request sampled in IDLE, completion in BUSY). No back-to-back grants.
//  A non-owner, or the owner before completion, sees waitrequest=1. readdata is 0 when not completing.
//  d_read && d_write together is illegal: the write wins and the read is not performed.
//  A requester that drops its request mid-transfer does not abort the slave transfer; it finishes from latched regs.
//  Reset asserted mid-transfer: state returns to IDLE immediately and m_read/m_write drop asynchronously.
//   The interrupted transfer is not replayed.
//  Address wrap-around is not interpreted; addresses pass through unchanged.
// CONFIGURATION
//  MIPS_MEM_ARB_PERF_EN defined: adds the ports below.
//   perf_clear in 1: synchronous clear, has priority over increments.
//   perf_i_grants out 32, perf_d_grants out 32, perf_stall_cycles out 32.
//   A grant counter increments on each IDLE->BUSY_x transition.
//   perf_stall_cycles counts cycles where a requester is blocked by the other owner or by m_waitrequest.
//   All counters saturate at 32'hFFFFFFFF and reset to 0.
//  Macro undefined: no counter logic and no perf ports. Arbitration behaviour is identical.
// STRUCTURE
//  Package mips_mem_arb_pkg holds:
//   arb_state_t enum {IDLE, BUSY_I, BUSY_D}
//   grant_t enum {GNT_INSTR, GNT_DATA}
//   localparam BE_ALL = '1
//  Sub-module mips_mem_arb_perf holds the three saturating counters. It is instantiated only under MIPS_MEM_ARB_PERF_EN.
// TESTING
//  Fetch only, i_address=BFC00000, slave 0-wait returns 24020012
//   -> m_read at cycle 1, i_waitrequest=0 with i_readdata=24020012 at cycle 1.
//  Data write only: d_address=00000004, d_writedata=DEADBEEF, be=4'b1111, slave 2 waits
//   -> m_write held 3 cycles with stable addr/data, d_waitrequest low on the 3rd.
//  i_read and d_read held together for 8 cycles, slave 0-wait
//   -> grants alternate I,D,I,D starting with I (last_grant reset to DATA).
//  d_read and d_write both high -> m_write=1, m_read=0, RAM updated, d_readdata=0.
//  Reset pulsed during BUSY_D with m_waitrequest=1 -> m_write falls in the same time step.
//   Then state is IDLE and both waitrequests are 1.
//  PERF_EN: 3 fetches + 2 loads, then perf_clear -> counters read 3,2,n, then 0,0,0 next cycle.

Source files
------------

// File: rtl/mips_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_arb_pkg
// Brief    : Shared types and helpers for the fetch/data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mips_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_INSTR = 1'b0,
      GNT_DATA  = 1'b1
   } grant_t;

   // Wide enough for any sensible data width; sliced to DATA_W/8 at use.
   localparam logic [127:0] BE_ALL = '1;

   // Round-robin choice: on a tie the side that did not win last time wins.
   function automatic grant_t pick_grant(input logic   i_req,
                                         input logic   d_req,
                                         input grant_t last);
      if (i_req && d_req)
         return (last == GNT_DATA) ? GNT_INSTR : GNT_DATA;
      else if (i_req)
         return GNT_INSTR;
      else
         return GNT_DATA;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mips_mem_arb_perf.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_arb_perf
// Brief    : Saturating grant / stall counters for the memory arbiter.
//            Only instantiated when MIPS_MEM_ARB_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mem_arb_perf (
   input  logic        clk,
   input  logic        reset,
   input  logic        perf_clear,
   input  logic        inc_i,
   input  logic        inc_d,
   input  logic        inc_stall,
   output logic [31:0] perf_i_grants,
   output logic [31:0] perf_d_grants,
   output logic [31:0] perf_stall_cycles
);

   localparam logic [31:0] C_MAX = 32'hFFFF_FFFF;

   logic [31:0] r_i_grants;
   logic [31:0] r_d_grants;
   logic [31:0] r_stall;

   // Clear wins over increments; each counter sticks at its maximum.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_i_grants <= '0;
         r_d_grants <= '0;
         r_stall    <= '0;
      end else if (perf_clear) begin
         r_i_grants <= '0;
         r_d_grants <= '0;
         r_stall    <= '0;
      end else begin
         if (inc_i && (r_i_grants != C_MAX))
            r_i_grants <= r_i_grants + 32'd1;
         if (inc_d && (r_d_grants != C_MAX))
            r_d_grants <= r_d_grants + 32'd1;
         if (inc_stall && (r_stall != C_MAX))
            r_stall <= r_stall + 32'd1;
      end
   end

   assign perf_i_grants     = r_i_grants;
   assign perf_d_grants     = r_d_grants;
   assign perf_stall_cycles = r_stall;

endmodule
`default_nettype wire

// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_arbiter
// Brief    : Round-robin arbiter sharing one Avalon-style memory port between
//            an instruction-fetch master and a data master. The granted
//            request is latched so the slave sees stable signals.
//            Optional macro MIPS_MEM_ARB_PERF_EN adds performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mem_arbiter
   import mips_mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_read,
   input  logic [ADDR_W-1:0]   i_address,
   output logic [DATA_W-1:0]   i_readdata,
   output logic                i_waitrequest,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [ADDR_W-1:0]   d_address,
   input  logic [DATA_W-1:0]   d_writedata,
   input  logic [DATA_W/8-1:0] d_byteenable,
   output logic [DATA_W-1:0]   d_readdata,
   output logic                d_waitrequest,
   output logic                m_read,
   output logic                m_write,
   output logic [ADDR_W-1:0]   m_address,
   output logic [DATA_W-1:0]   m_writedata,
   output logic [DATA_W/8-1:0] m_byteenable,
   input  logic [DATA_W-1:0]   m_readdata,
   input  logic                m_waitrequest
`ifdef MIPS_MEM_ARB_PERF_EN
   ,
   input  logic                perf_clear,
   output logic [31:0]         perf_i_grants,
   output logic [31:0]         perf_d_grants,
   output logic [31:0]         perf_stall_cycles
`endif
);

   arb_state_t          r_state;
   grant_t              r_last;
   logic                r_read;
   logic                r_write;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W/8-1:0] r_be;

   logic   w_d_req;
   grant_t w_grant;
   logic   w_i_done;
   logic   w_d_done;

   assign w_d_req = d_read | d_write;
   assign w_grant = pick_grant(i_read, w_d_req, r_last);

   // Arbitration FSM: grant in IDLE, hold latched request until the slave completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_last  <= GNT_DATA;
         r_read  <= 1'b0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_read || w_d_req) begin
                  r_last <= w_grant;
                  if (w_grant == GNT_INSTR) begin
                     r_state <= BUSY_I;
                     r_read  <= 1'b1;
                     r_write <= 1'b0;
                     r_addr  <= i_address;
                     r_be    <= BE_ALL[DATA_W/8-1:0];
                  end else begin
                     // Simultaneous read and write: the write wins.
                     r_state <= BUSY_D;
                     r_read  <= d_read & ~d_write;
                     r_write <= d_write;
                     r_addr  <= d_address;
                     r_wdata <= d_writedata;
                     r_be    <= d_byteenable;
                  end
               end
            end
            BUSY_I, BUSY_D: begin
               if (!m_waitrequest) begin
                  r_state <= IDLE;
                  r_read  <= 1'b0;
                  r_write <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_read  <= 1'b0;
               r_write <= 1'b0;
            end
         endcase
      end
   end

   assign m_read       = r_read;
   assign m_write      = r_write;
   assign m_address    = r_addr;
   assign m_writedata  = r_wdata;
   assign m_byteenable = r_be;

   // Completion is combinational so the owner is released in the slave's last cycle.
   assign w_i_done = (r_state == BUSY_I) && !m_waitrequest;
   assign w_d_done = (r_state == BUSY_D) && !m_waitrequest;

   assign i_waitrequest = ~w_i_done;
   assign d_waitrequest = ~w_d_done;
   assign i_readdata    = w_i_done ? m_readdata : '0;
   assign d_readdata    = (w_d_done && r_read) ? m_readdata : '0;

`ifdef MIPS_MEM_ARB_PERF_EN
   logic w_inc_i;
   logic w_inc_d;
   logic w_stall;

   assign w_inc_i = (r_state == IDLE) && (i_read || w_d_req) && (w_grant == GNT_INSTR);
   assign w_inc_d = (r_state == IDLE) && (i_read || w_d_req) && (w_grant == GNT_DATA);
   // A live request held off by the other owner or by a slave stall.
   assign w_stall = (r_state != IDLE) &&
                    ((i_read && i_waitrequest) || (w_d_req && d_waitrequest));

   mips_mem_arb_perf u_perf (
      .clk               (clk),
      .reset             (reset),
      .perf_clear        (perf_clear),
      .inc_i             (w_inc_i),
      .inc_d             (w_inc_d),
      .inc_stall         (w_stall),
      .perf_i_grants     (perf_i_grants),
      .perf_d_grants     (perf_d_grants),
      .perf_stall_cycles (perf_stall_cycles)
   );
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mem_arbiter
// Brief    : Directed self-checking bench for mips_mem_arbiter with a small
//            wait-state RAM slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        i_read;
   logic [31:0] i_address;
   logic [31:0] i_readdata;
   logic        i_waitrequest;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_address;
   logic [31:0] d_writedata;
   logic [3:0]  d_byteenable;
   logic [31:0] d_readdata;
   logic        d_waitrequest;
   logic        m_read;
   logic        m_write;
   logic [31:0] m_address;
   logic [31:0] m_writedata;
   logic [3:0]  m_byteenable;
   logic [31:0] m_readdata;
   logic        m_waitrequest;
`ifdef MIPS_MEM_ARB_PERF_EN
   logic        perf_clear;
   logic [31:0] perf_i_grants;
   logic [31:0] perf_d_grants;
   logic [31:0] perf_stall_cycles;
`endif

   int errors = 0;
   int checks = 0;

   // slave model
   logic [31:0] mem [0:15];
   int          slave_waits;
   int          wait_cnt;

   mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .i_read        (i_read),
      .i_address     (i_address),
      .i_readdata    (i_readdata),
      .i_waitrequest (i_waitrequest),
      .d_read        (d_read),
      .d_write       (d_write),
      .d_address     (d_address),
      .d_writedata   (d_writedata),
      .d_byteenable  (d_byteenable),
      .d_readdata    (d_readdata),
      .d_waitrequest (d_waitrequest),
      .m_read        (m_read),
      .m_write       (m_write),
      .m_address     (m_address),
      .m_writedata   (m_writedata),
      .m_byteenable  (m_byteenable),
      .m_readdata    (m_readdata),
      .m_waitrequest (m_waitrequest)
`ifdef MIPS_MEM_ARB_PERF_EN
      ,
      .perf_clear        (perf_clear),
      .perf_i_grants     (perf_i_grants),
      .perf_d_grants     (perf_d_grants),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign m_waitrequest = (m_read || m_write) && (wait_cnt < slave_waits);
   assign m_readdata    = mem[m_address[5:2]];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= 0;
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[0] <= 32'h2402_0012;
         mem[2] <= 32'hA5A5_5A5A;
      end else begin
         if ((m_read || m_write) && m_waitrequest) wait_cnt <= wait_cnt + 1;
         else wait_cnt <= 0;
         if (m_write && !m_waitrequest)
            for (int b = 0; b < 4; b++)
               if (m_byteenable[b]) mem[m_address[5:2]][8*b +: 8] <= m_writedata[8*b +: 8];
      end
   end

   task automatic test_reset();
      checks++; if (i_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_i_wait got=%b exp=1", i_waitrequest); end
      checks++; if (d_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_d_wait got=%b exp=1", d_waitrequest); end
      checks++; if ({m_read, m_write} !== 2'b00) begin errors++; $display("FAIL rst_m_rw got=%b exp=00", {m_read, m_write}); end
      checks++; if (m_address !== 32'h0) begin errors++; $display("FAIL rst_m_addr got=%h exp=0", m_address); end
      checks++; if (m_byteenable !== 4'h0) begin errors++; $display("FAIL rst_m_be got=%h exp=0", m_byteenable); end
      checks++; if (i_readdata !== 32'h0 || d_readdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h/%h exp=0/0", i_readdata, d_readdata); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (i_waitrequest !== 1'b1 || m_read !== 1'b0) begin errors++; $display("FAIL idle_after_rst got=%b%b exp=10", i_waitrequest, m_read); end
   endtask

   task automatic test_fetch();
      slave_waits = 0;
      i_read = 1'b1; i_address = 32'hBFC0_0000;
      @(negedge clk);
      checks++; if (m_read !== 1'b1 || m_write !== 1'b0) begin errors++; $display("FAIL fetch_m_read got=%b%b exp=10", m_read, m_write); end
      checks++; if (m_address !== 32'hBFC0_0000) begin errors++; $display("FAIL fetch_addr got=%h exp=bfc00000", m_address); end
      checks++; if (m_byteenable !== 4'hF) begin errors++; $display("FAIL fetch_be got=%h exp=f", m_byteenable); end
      checks++; if (i_waitrequest !== 1'b0 || d_waitrequest !== 1'b1) begin errors++; $display("FAIL fetch_wait got=%b%b exp=01", i_waitrequest, d_waitrequest); end
      checks++; if (i_readdata !== 32'h2402_0012) begin errors++; $display("FAIL fetch_rdata got=%h exp=24020012", i_readdata); end
      i_read = 1'b0;
      @(negedge clk);
      checks++; if (m_read !== 1'b0 || i_waitrequest !== 1'b1 || i_readdata !== 32'h0) begin errors++; $display("FAIL fetch_end got=%b%b %h exp=01 0", m_read, i_waitrequest, i_readdata); end
   endtask

   task automatic test_write();
      slave_waits = 2;
      d_write = 1'b1; d_address = 32'h0000_0004; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'hF;
      @(negedge clk);
      checks++; if (m_write !== 1'b1 || d_waitrequest !== 1'b1) begin errors++; $display("FAIL wr_c1 got=%b%b exp=11", m_write, d_waitrequest); end
      // requester drops out; the slave transfer continues from latched values
      d_write = 1'b0; d_address = 32'h0000_0040; d_writedata = 32'h0;
      @(negedge clk);
      checks++; if (m_write !== 1'b1 || d_waitrequest !== 1'b1) begin errors++; $display("FAIL wr_c2 got=%b%b exp=11", m_write, d_waitrequest); end
      checks++; if (m_address !== 32'h4 || m_writedata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_stable got=%h %h exp=4 deadbeef", m_address, m_writedata); end
      @(negedge clk);
      checks++; if (m_write !== 1'b1 || d_waitrequest !== 1'b0) begin errors++; $display("FAIL wr_c3 got=%b%b exp=10", m_write, d_waitrequest); end
      @(negedge clk);
      checks++; if (m_write !== 1'b0 || mem[1] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_done got=%b %h exp=0 deadbeef", m_write, mem[1]); end
      slave_waits = 0;
   endtask

   task automatic test_round_robin();
      logic exp_i;
      i_read = 1'b1; i_address = 32'h0;
      d_read = 1'b1; d_address = 32'h8; d_byteenable = 4'hF;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k % 2 == 0) begin
            exp_i = (k % 4 == 0);
            checks++; if (m_read !== 1'b1 || m_address !== (exp_i ? 32'h0 : 32'h8)) begin errors++; $display("FAIL rr_grant k=%0d got=%b %h exp=1 %h", k, m_read, m_address, exp_i ? 32'h0 : 32'h8); end
            checks++; if (i_waitrequest !== ~exp_i || d_waitrequest !== exp_i) begin errors++; $display("FAIL rr_wait k=%0d got=%b%b exp=%b%b", k, i_waitrequest, d_waitrequest, ~exp_i, exp_i); end
            checks++; if (i_readdata !== (exp_i ? 32'h2402_0012 : 32'h0) || d_readdata !== (exp_i ? 32'h0 : 32'hA5A5_5A5A)) begin errors++; $display("FAIL rr_rdata k=%0d got=%h %h", k, i_readdata, d_readdata); end
         end else begin
            checks++; if (m_read !== 1'b0 || i_waitrequest !== 1'b1 || d_waitrequest !== 1'b1) begin errors++; $display("FAIL rr_gap k=%0d got=%b%b%b exp=011", k, m_read, i_waitrequest, d_waitrequest); end
         end
      end
      i_read = 1'b0; d_read = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read_write_both();
      d_read = 1'b1; d_write = 1'b1; d_address = 32'hC; d_writedata = 32'h1234_5678; d_byteenable = 4'hF;
      @(negedge clk);
      checks++; if (m_write !== 1'b1 || m_read !== 1'b0) begin errors++; $display("FAIL rw_strobes got=w%b r%b exp=w1 r0", m_write, m_read); end
      checks++; if (d_waitrequest !== 1'b0 || d_readdata !== 32'h0) begin errors++; $display("FAIL rw_resp got=%b %h exp=0 0", d_waitrequest, d_readdata); end
      d_read = 1'b0; d_write = 1'b0;
      @(negedge clk);
      checks++; if (mem[3] !== 32'h1234_5678) begin errors++; $display("FAIL rw_ram got=%h exp=12345678", mem[3]); end
   endtask

   task automatic test_async_reset();
      slave_waits = 100;
      d_write = 1'b1; d_address = 32'h10; d_writedata = 32'hCAFE_F00D; d_byteenable = 4'hF;
      @(negedge clk);
      checks++; if (m_write !== 1'b1 || d_waitrequest !== 1'b1) begin errors++; $display("FAIL ar_busy got=%b%b exp=11", m_write, d_waitrequest); end
      d_write = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++; if (m_write !== 1'b0 || m_address !== 32'h0) begin errors++; $display("FAIL ar_drop got=%b %h exp=0 0", m_write, m_address); end
      @(negedge clk);
      reset = 1'b0; slave_waits = 0;
      @(negedge clk);
      checks++; if ({m_read, m_write, i_waitrequest, d_waitrequest} !== 4'b0011) begin errors++; $display("FAIL ar_idle got=%b exp=0011", {m_read, m_write, i_waitrequest, d_waitrequest}); end
   endtask

`ifdef MIPS_MEM_ARB_PERF_EN
   task automatic test_perf();
      slave_waits = 0;
      for (int j = 0; j < 3; j++) begin
         i_read = 1'b1; i_address = j * 4;
         @(negedge clk);
         i_read = 1'b0;
         @(negedge clk);
      end
      slave_waits = 1;
      for (int j = 0; j < 2; j++) begin
         d_read = 1'b1; d_address = 32'h8; d_byteenable = 4'hF;
         @(negedge clk);
         @(negedge clk);
         d_read = 1'b0;
         @(negedge clk);
      end
      slave_waits = 0;
      checks++; if (perf_i_grants !== 32'd3) begin errors++; $display("FAIL perf_i got=%0d exp=3", perf_i_grants); end
      checks++; if (perf_d_grants !== 32'd2) begin errors++; $display("FAIL perf_d got=%0d exp=2", perf_d_grants); end
      checks++; if (perf_stall_cycles !== 32'd2) begin errors++; $display("FAIL perf_stall got=%0d exp=2", perf_stall_cycles); end
      perf_clear = 1'b1;
      @(negedge clk);
      perf_clear = 1'b0;
      checks++; if ({perf_i_grants, perf_d_grants, perf_stall_cycles} !== 96'h0) begin errors++; $display("FAIL perf_clear got=%0d %0d %0d exp=0 0 0", perf_i_grants, perf_d_grants, perf_stall_cycles); end
   endtask
`endif

   initial begin
      reset = 1'b1;
      i_read = 1'b0; i_address = '0;
      d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0; d_byteenable = '0;
      slave_waits = 0;
`ifdef MIPS_MEM_ARB_PERF_EN
      perf_clear = 1'b0;
`endif
      repeat (2) @(negedge clk);
      test_reset();
      test_fetch();
      test_write();
      test_round_robin();
      test_read_write_both();
      test_async_reset();
`ifdef MIPS_MEM_ARB_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
